// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared widths, status bit indices and serializer state
package fifo_stream_pkg;
    localparam int IN_W  = 256;
    localparam int OUT_W = 64;
    localparam int BEATS = IN_W / OUT_W;
    localparam int BW    = $clog2(BEATS);

    localparam int ST_AFULL = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OPEN  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;
endpackage

// File: rtl/fifo_stream_serializer_if.sv
// rtl/fifo_stream_serializer_if.sv - upstream write port plus serialized beat stream
interface fifo_stream_serializer_if;
    import fifo_stream_pkg::*;

    logic [IN_W-1:0]  fifo_data;
    logic             fifo_write;
    logic             fifo_send;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop;
    logic             out_eop;
    logic [3:0]       status;
    logic [15:0]      drop_count;

    modport master (
        output fifo_data, fifo_write, fifo_send, out_ready,
        input  out_data, out_valid, out_sop, out_eop, status, drop_count
    );

    modport slave (
        input  fifo_data, fifo_write, fifo_send, out_ready,
        output out_data, out_valid, out_sop, out_eop, status, drop_count
    );
endinterface

// File: rtl/fifo_stream_buf.sv
// rtl/fifo_stream_buf.sv - sync FIFO of 256-bit words with per-entry last flag
module fifo_stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [IN_W-1:0] push_data_i,
    input  logic            push_last_i,
    input  logic            pop_i,
    input  logic            tail_last_set_i,
    output logic [IN_W-1:0] pop_data_o,
    output logic            pop_last_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [AW:0]     count_o
);
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [AW-1:0]    wr_idx, rd_idx, tail_idx;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign tail_idx = wr_idx - AW'(1);

    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign empty_o    = (count_o == '0);
    assign full_o     = (count_o == (AW+1)'(DEPTH));
    assign pop_data_o = mem_q[rd_idx];
    assign pop_last_o = last_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (push_i)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i)
                last_q[wr_idx] <= push_last_i;
            else if (tail_last_set_i)
                last_q[tail_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[wr_idx] <= push_data_i;
    end
endmodule

// File: rtl/fifo_stream_serializer.sv
// rtl/fifo_stream_serializer.sv - buffers 256-bit words and emits them as 64-bit packet beats
module fifo_stream_serializer
    import fifo_stream_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input logic                     clk_clk,
    input logic                     reset_reset,
    fifo_stream_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    ser_state_e      state_q, state_d;
    logic [IN_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            last_q, last_d;
    logic            pkt_open_q, pkt_open_d;
    logic            ovf_q;
    logic [15:0]     drop_q;

    logic            push, pop, drop, fire, last_beat;
    logic            send_rule, tail_set, tail_hit, ser_last_set;
    logic [IN_W-1:0] pop_data;
    logic            pop_last, empty, full;
    logic [AW:0]     count;
    logic            valid_o, sop_o, eop_o;

    fifo_stream_buf #(.DEPTH(DEPTH)) u_buf (
        .clk_i          (clk_clk),
        .rst_i          (reset_reset),
        .push_i         (push),
        .push_data_i    (bus.fifo_data),
        .push_last_i    (bus.fifo_send),
        .pop_i          (pop),
        .tail_last_set_i(tail_set),
        .pop_data_o     (pop_data),
        .pop_last_o     (pop_last),
        .empty_o        (empty),
        .full_o         (full),
        .count_o        (count)
    );

    // Full is judged before this cycle's pop, so a write into a full FIFO drops.
    assign push      = bus.fifo_write & ~full;
    assign drop      = bus.fifo_write & full;
    assign fire      = valid_o & bus.out_ready;
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign pop       = ~empty & ((state_q == IDLE) | (fire & last_beat));

    // A send that cannot ride on an accepted write closes the newest buffered word.
    assign send_rule    = bus.fifo_send & (~bus.fifo_write | full);
    assign tail_set     = send_rule & ~empty;
    assign tail_hit     = tail_set & pop & (count == (AW+1)'(1));
    assign ser_last_set = send_rule & empty & (state_q == SHIFT);

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = SHIFT;
            SHIFT:   if (fire && last_beat && empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_o = (state_q == SHIFT);
        sop_o   = valid_o & (beat_q == '0) & ~pkt_open_q;
        eop_o   = valid_o & last_beat & last_q;
    end

    always_comb begin
        shreg_d    = shreg_q;
        beat_d     = beat_q;
        last_d     = last_q;
        pkt_open_d = pkt_open_q;
        if (pop) begin
            shreg_d = pop_data;
            beat_d  = '0;
            last_d  = pop_last | tail_hit;
        end else if (fire) begin
            shreg_d = shreg_q >> OUT_W;
            beat_d  = beat_q + 1'b1;
        end
        if (ser_last_set)
            last_d = 1'b1;
        if (fire && eop_o)
            pkt_open_d = 1'b0;
        else if (fire && beat_q == '0)
            pkt_open_d = 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            shreg_q    <= '0;
            beat_q     <= '0;
            last_q     <= 1'b0;
            pkt_open_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            shreg_q    <= shreg_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            pkt_open_q <= pkt_open_d;
            if (drop)
                ovf_q <= 1'b1;
            if (drop && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.out_data   = shreg_q[OUT_W-1:0];
    assign bus.out_valid  = valid_o;
    assign bus.out_sop    = sop_o;
    assign bus.out_eop    = eop_o;
    assign bus.drop_count = drop_q;

    assign bus.status[ST_AFULL] = (count >= (AW+1)'(AFULL_LEVEL));
    assign bus.status[ST_OVF]   = ovf_q;
    assign bus.status[ST_EMPTY] = empty & (state_q == IDLE);
    assign bus.status[ST_OPEN]  = pkt_open_q | ~empty | (state_q == SHIFT);
endmodule

// File: tb/tb_fifo_stream_serializer.sv
// tb/tb_fifo_stream_serializer.sv - directed self-checking bench for fifo_stream_serializer
module tb_fifo_stream_serializer;
    import fifo_stream_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_stream_serializer_if bus();

    fifo_stream_serializer #(.DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [63:0] q_data[$];
    bit          q_sop[$];
    bit          q_eop[$];
    int          q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            q_data.push_back(bus.out_data);
            q_sop.push_back(bus.out_sop);
            q_eop.push_back(bus.out_eop);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [255:0] mkword(input logic [7:0] base);
        logic [255:0] w;
        for (int i = 0; i < 32; i++)
            w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    function automatic logic [63:0] beat_of(input logic [255:0] w, input int b);
        return w[b*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [255:0] d, input logic s);
        bus.fifo_data  = d;
        bus.fifo_write = 1'b1;
        bus.fifo_send  = s;
        tick();
        bus.fifo_write = 1'b0;
        bus.fifo_send  = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (q_data.size() < n)
            chk("beat_timeout", 64'(q_data.size()), 64'(n));
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sop.delete();
        q_eop.delete();
        q_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({pfx, "_sop"}, 64'(bus.out_sop), 64'd0);
        chk({pfx, "_eop"}, 64'(bus.out_eop), 64'd0);
        chk({pfx, "_data"}, bus.out_data, 64'd0);
        chk({pfx, "_status"}, 64'(bus.status), 64'h4);
        chk({pfx, "_drop"}, 64'(bus.drop_count), 64'd0);
    endtask

    logic [255:0] w0, w1, w2, wl [20];

    initial begin
        rst            = 1'b1;
        bus.fifo_data  = '0;
        bus.fifo_write = 1'b0;
        bus.fifo_send  = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Single word: beat 0 valid two cycles after the write.
        bus.out_ready = 1'b1;
        w0 = mkword(8'h00);
        put(w0, 1'b1);
        chk("t1_valid_t1", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t1_valid_t2", 64'(bus.out_valid), 64'd1);
        wait_beats(4, 20);
        chk("t1_beat0", q_data[0], 64'h0706050403020100);
        chk("t1_beat3", q_data[3], 64'h1f1e1d1c1b1a1918);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_sop%0d", i), 64'(q_sop[i]), 64'(i == 0));
            chk($sformatf("t1_eop%0d", i), 64'(q_eop[i]), 64'(i == 3));
        end
        chk("t1_gapless", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
        tick();
        tick();
        chk("t1_status", 64'(bus.status), 64'h4);

        // Backpressure at beat 2, two words back to back.
        clear_q();
        w0 = mkword(8'h40);
        w1 = mkword(8'h80);
        put(w0, 1'b0);
        put(w1, 1'b1);
        for (int k = 0; k < 20 && q_data.size() < 2; k++) tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_data", bus.out_data, beat_of(w0, 2));
            chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        wait_beats(8, 30);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_data%0d", i), q_data[i], beat_of(i < 4 ? w0 : w1, i % 4));
            chk($sformatf("t2_sop%0d", i), 64'(q_sop[i]), 64'(i == 0));
            chk($sformatf("t2_eop%0d", i), 64'(q_eop[i]), 64'(i == 7));
        end
        for (int i = 0; i < 7; i++)
            chk($sformatf("t2_gap%0d", i), 64'(q_cyc[i+1] - q_cyc[i]), (i == 1) ? 64'd6 : 64'd1);

        // Late send closes the newest buffered word.
        clear_q();
        w0 = mkword(8'h20);
        w1 = mkword(8'h60);
        w2 = mkword(8'hA0);
        put(w0, 1'b0);
        put(w1, 1'b0);
        put(w2, 1'b0);
        bus.fifo_send = 1'b1;
        tick();
        bus.fifo_send = 1'b0;
        wait_beats(12, 40);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t3_eop%0d", i), 64'(q_eop[i]), 64'(i == 11));
            chk($sformatf("t3_sop%0d", i), 64'(q_sop[i]), 64'(i == 0));
        end
        chk("t3_data4", q_data[4], beat_of(w1, 0));
        chk("t3_data11", q_data[11], beat_of(w2, 3));
        repeat (5) tick();
        bus.fifo_send = 1'b1;
        tick();
        bus.fifo_send = 1'b0;
        repeat (10) tick();
        chk("t3_no_extra", 64'(q_data.size()), 64'd12);
        chk("t3_status", 64'(bus.status), 64'h4);

        // Overflow then counter saturation with the consumer stalled.
        clear_q();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            wl[k] = mkword(8'(k * 8 + 1));
            put(wl[k], 1'b0);
        end
        tick();
        chk("t4_drop3", 64'(bus.drop_count), 64'd3);
        chk("t4_status", 64'(bus.status), 64'hB);
        chk("t4_head", bus.out_data, beat_of(wl[0], 0));
        bus.fifo_write = 1'b1;
        repeat (69997) tick();
        bus.fifo_write = 1'b0;
        tick();
        chk("t4_drop_sat", 64'(bus.drop_count), 64'hFFFF);
        chk("t4_ovf_sticky", 64'(bus.status[ST_OVF]), 64'd1);
        bus.out_ready = 1'b1;
        wait_beats(68, 200);
        repeat (10) tick();
        chk("t4_beats", 64'(q_data.size()), 64'd68);
        chk("t4_first", q_data[0], beat_of(wl[0], 0));
        chk("t4_w16_b0", q_data[64], beat_of(wl[16], 0));
        chk("t4_w16_b3", q_data[67], beat_of(wl[16], 3));
        chk("t4_status_end", 64'(bus.status), 64'hE);

        // Reset in the middle of a packet.
        clear_q();
        put(mkword(8'h33), 1'b0);
        for (int k = 0; k < 20 && q_data.size() < 2; k++) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        clear_q();
        w0 = mkword(8'h55);
        put(w0, 1'b1);
        wait_beats(4, 20);
        chk("t5_sop", 64'(q_sop[0]), 64'd1);
        chk("t5_eop", 64'(q_eop[3]), 64'd1);
        chk("t5_data0", q_data[0], beat_of(w0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
